ir_decode_stage: RTL

//   Registered, parametrised instruction-decode stage with valid/ready handshake on both sides.

---
 rtl/ir_pkg.sv | 51 +++++
 rtl/ir_field_decode.sv | 83 ++++++++
 rtl/ir_decode_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// ----------------------------------------------------------------------------
// ir_pkg
//   Shared definitions for the instruction-decode stage: instruction-type
//   encodings, fixed bit positions of every field inside a 32-bit instruction
//   word, the decoded-record struct and a field extraction helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package ir_pkg;

  localparam int IR_WORD_W      = 32;
  localparam int IR_REG_FIELD_W = 5;

  // Field bit positions (LSB of each field) inside the 32-bit word
  localparam int IR_STOP_BIT  = 0;
  localparam int IR_TYPE_LSB  = 1;
  localparam int IR_IMM_LSB   = 3;
  localparam int IR_SA_LSB    = 7;
  localparam int IR_RS2_LSB   = 12;
  localparam int IR_RD_LSB    = 17;
  localparam int IR_RS1_LSB   = 22;
  localparam int IR_FUNC_LSB  = 27;
  localparam int IR_IMM14_W   = 14;
  localparam int IR_IMM24_W   = 24;

  typedef enum logic [1:0] {
    IR_TYPE_R = 2'b00,
    IR_TYPE_J = 2'b01,
    IR_TYPE_I = 2'b10,
    IR_TYPE_S = 2'b11
  } ir_type_e;

  // Decoded record without the extended immediate (its width is a
  // per-instance parameter, so it travels alongside this struct).
  typedef struct packed {
    ir_type_e    typ;
    logic [4:0]  func;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic        stop;
  } ir_rec_t;

  // Extract a 5-bit field whose LSB sits at position lsb.
  function automatic logic [4:0] ir_field5(input logic [31:0] word, input int unsigned lsb);
    logic [31:0] shifted;
    shifted   = word >> lsb;
    ir_field5 = shifted[4:0];
  endfunction

endpackage

// File: rtl/ir_field_decode.sv
// ----------------------------------------------------------------------------
// ir_field_decode
//   Purely combinational split of one instruction word into a decoded record
//   and an extended immediate. Fields not used by the instruction type are
//   forced to 0.
// Ports:
//   i_inst  in   INST_W   instruction word (bits above 31 are ignored)
//   o_rec   out  ir_rec_t type/func/register indices/shift amount/stop bit
//   o_imm   out  DATA_W   imm14 (I) or imm24 (J), sign- or zero-extended
// ----------------------------------------------------------------------------
module ir_field_decode
  import ir_pkg::*;
#(
  parameter int INST_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEXT_IMM = 1
) (
  input  logic [INST_W-1:0] i_inst,
  output ir_rec_t           o_rec,
  output logic [DATA_W-1:0] o_imm
);

  logic [IR_WORD_W-1:0]  w_word;
  logic [IR_IMM14_W-1:0] w_imm14;
  logic [IR_IMM24_W-1:0] w_imm24;
  ir_type_e              w_type;

  assign w_word  = i_inst[IR_WORD_W-1:0];
  assign w_imm14 = w_word[IR_IMM_LSB +: IR_IMM14_W];
  assign w_imm24 = w_word[IR_IMM_LSB +: IR_IMM24_W];
  assign w_type  = ir_type_e'(w_word[IR_TYPE_LSB +: 2]);

  generate
    if (INST_W > IR_WORD_W) begin : g_wide
      logic w_unused_hi;
      assign w_unused_hi = ^i_inst[INST_W-1:IR_WORD_W];
    end
  endgenerate

  function automatic logic [DATA_W-1:0] ext14(input logic [IR_IMM14_W-1:0] v);
    if (SEXT_IMM != 0) ext14 = {{(DATA_W-IR_IMM14_W){v[IR_IMM14_W-1]}}, v};
    else               ext14 = {{(DATA_W-IR_IMM14_W){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] ext24(input logic [IR_IMM24_W-1:0] v);
    if (SEXT_IMM != 0) ext24 = {{(DATA_W-IR_IMM24_W){v[IR_IMM24_W-1]}}, v};
    else               ext24 = {{(DATA_W-IR_IMM24_W){1'b0}}, v};
  endfunction

  // Type-dependent field selection; everything unused stays 0
  always_comb begin
    o_rec      = '0;
    o_imm      = '0;
    o_rec.typ  = w_type;
    o_rec.func = ir_field5(w_word, IR_FUNC_LSB);
    o_rec.stop = w_word[IR_STOP_BIT];
    case (w_type)
      IR_TYPE_R: begin
        o_rec.rs1 = ir_field5(w_word, IR_RS1_LSB);
        o_rec.rs2 = ir_field5(w_word, IR_RS2_LSB);
        o_rec.rd  = ir_field5(w_word, IR_RD_LSB);
      end
      IR_TYPE_I: begin
        o_rec.rs1 = ir_field5(w_word, IR_RS1_LSB);
        o_rec.rd  = ir_field5(w_word, IR_RD_LSB);
        o_imm     = ext14(w_imm14);
      end
      IR_TYPE_J: begin
        o_imm     = ext24(w_imm24);
      end
      IR_TYPE_S: begin
        o_rec.rs1 = ir_field5(w_word, IR_RS1_LSB);
        o_rec.rs2 = ir_field5(w_word, IR_RS2_LSB);
        o_rec.rd  = ir_field5(w_word, IR_RD_LSB);
        o_rec.sa  = ir_field5(w_word, IR_SA_LSB);
      end
      default: begin
        o_rec.rs1 = 5'd0;
      end
    endcase
  end

endmodule

// File: rtl/ir_decode_stage.sv
// ----------------------------------------------------------------------------
// ir_decode_stage
//   Registered instruction-decode stage between fetch and register-read.
//   Decoded records are held in a 2-entry skid buffer (strict FIFO order,
//   nothing dropped under back-pressure); a bundle counter assigns each
//   accepted instruction its slot inside a stop-bit bundle.
//   Optional feature macro: IR_PERF_CNT_EN -- builds a saturating count of
//   output handshakes on out_inst_cnt (cleared by reset only); when the macro
//   is undefined out_inst_cnt is tied to 0.
// Ports:
//   clk, reset (sync, active-high), flush (sync discard)
//   in_valid/in_ready/in_inst      fetch-side handshake, in_ready registered
//   out_valid/out_ready            consumer-side handshake
//   out_type/out_func/out_rs1/out_rs2/out_rd/out_sa/out_imm/out_stop
//                                  decoded fields of the head record
//   out_slot/out_bundle_err        bundle position / forced-bundle-end flag
//   out_inst_cnt                   decoded-instruction count
// ----------------------------------------------------------------------------
module ir_decode_stage
  import ir_pkg::*;
#(
  parameter int INST_W     = 32,
  parameter int REG_IDX_W  = 5,
  parameter int DATA_W     = 32,
  parameter int SEXT_IMM   = 1,
  parameter int MAX_BUNDLE = 4,
  localparam int SLOT_W    = (MAX_BUNDLE > 1) ? $clog2(MAX_BUNDLE) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INST_W-1:0]    in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_type,
  output logic [4:0]           out_func,
  output logic [REG_IDX_W-1:0] out_rs1,
  output logic [REG_IDX_W-1:0] out_rs2,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [4:0]           out_sa,
  output logic [DATA_W-1:0]    out_imm,
  output logic                 out_stop,
  output logic [SLOT_W-1:0]    out_slot,
  output logic                 out_bundle_err,
  output logic [31:0]          out_inst_cnt
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAX_BUNDLE - 1);

  typedef struct packed {
    ir_rec_t           rec;
    logic [DATA_W-1:0] imm;
    logic [SLOT_W-1:0] slot;
    logic              err;
  } ent_t;

  ir_rec_t           w_rec;
  logic [DATA_W-1:0] w_imm;
  ent_t              w_new;
  logic              w_acc;
  logic              w_deq;
  logic [SLOT_W-1:0] w_cnt_nxt;
  logic [1:0]        w_occ_nxt;
  ent_t              w_ent0_nxt;
  ent_t              w_ent1_nxt;

  ent_t              r_ent0;     // head record, drives the outputs
  ent_t              r_ent1;     // skid entry behind the head
  logic [1:0]        r_occ;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [SLOT_W-1:0] r_slot_cnt;

  ir_field_decode #(
    .INST_W   (INST_W),
    .DATA_W   (DATA_W),
    .SEXT_IMM (SEXT_IMM)
  ) u_field_decode (
    .i_inst (in_inst),
    .o_rec  (w_rec),
    .o_imm  (w_imm)
  );

  assign w_acc = in_valid && r_in_ready;
  assign w_deq = r_out_valid && out_ready;

  // Build the incoming entry and the next bundle-counter value
  always_comb begin
    w_new.rec  = w_rec;
    w_new.imm  = w_imm;
    w_new.slot = r_slot_cnt;
    w_new.err  = !w_rec.stop && (r_slot_cnt == LAST_SLOT);
    if (!w_acc) begin
      w_cnt_nxt = r_slot_cnt;
    end else if (w_rec.stop) begin
      w_cnt_nxt = {SLOT_W{1'b0}};
    end else if (r_slot_cnt == LAST_SLOT) begin
      // bundle hit its size limit without a stop bit: end it here
      w_cnt_nxt = {SLOT_W{1'b0}};
    end else begin
      w_cnt_nxt = r_slot_cnt + SLOT_W'(1);
    end
  end

  // Skid-buffer next state; vacated entries are zeroed so no stale fields show
  always_comb begin
    w_occ_nxt  = r_occ;
    w_ent0_nxt = r_ent0;
    w_ent1_nxt = r_ent1;
    case (r_occ)
      2'd0: begin
        if (w_acc) begin
          w_ent0_nxt = w_new;
          w_occ_nxt  = 2'd1;
        end else begin
          w_occ_nxt  = 2'd0;
        end
      end
      2'd1: begin
        if (w_acc && w_deq) begin
          w_ent0_nxt = w_new;
        end else if (w_acc) begin
          w_ent1_nxt = w_new;
          w_occ_nxt  = 2'd2;
        end else if (w_deq) begin
          w_ent0_nxt = '0;
          w_occ_nxt  = 2'd0;
        end else begin
          w_occ_nxt  = 2'd1;
        end
      end
      2'd2: begin
        // in_ready is low here, so only a delivery can happen
        if (w_deq) begin
          w_ent0_nxt = r_ent1;
          w_ent1_nxt = '0;
          w_occ_nxt  = 2'd1;
        end else begin
          w_occ_nxt  = 2'd2;
        end
      end
      default: begin
        w_ent0_nxt = '0;
        w_ent1_nxt = '0;
        w_occ_nxt  = 2'd0;
      end
    endcase
  end

  // Buffer, handshake flags and bundle counter; reset and flush both empty the stage
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_ent0      <= '0;
      r_ent1      <= '0;
      r_occ       <= 2'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_slot_cnt  <= {SLOT_W{1'b0}};
    end else begin
      r_ent0      <= w_ent0_nxt;
      r_ent1      <= w_ent1_nxt;
      r_occ       <= w_occ_nxt;
      r_out_valid <= (w_occ_nxt != 2'd0);
      r_in_ready  <= (w_occ_nxt != 2'd2);
      r_slot_cnt  <= w_cnt_nxt;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_type       = r_ent0.rec.typ;
  assign out_func       = r_ent0.rec.func;
  assign out_rs1        = REG_IDX_W'(r_ent0.rec.rs1);
  assign out_rs2        = REG_IDX_W'(r_ent0.rec.rs2);
  assign out_rd         = REG_IDX_W'(r_ent0.rec.rd);
  assign out_sa         = r_ent0.rec.sa;
  assign out_imm        = r_ent0.imm;
  assign out_stop       = r_ent0.rec.stop;
  assign out_slot       = r_ent0.slot;
  assign out_bundle_err = r_ent0.err;

`ifdef IR_PERF_CNT_EN
  logic [31:0] r_inst_cnt;

  // Saturating handshake counter; survives flush, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_cnt <= 32'd0;
    end else if (w_deq && (r_inst_cnt != 32'hFFFF_FFFF)) begin
      r_inst_cnt <= r_inst_cnt + 32'd1;
    end else begin
      r_inst_cnt <= r_inst_cnt;
    end
  end

  assign out_inst_cnt = r_inst_cnt;
`else
  assign out_inst_cnt = 32'd0;
`endif

endmodule
